// File: rtl/lcd_pkg.sv
// lcd_pkg: shared LCD state encodings, bus widths, defaults and index-width helper
package lcd_pkg;

    localparam int LCD_ADDR_W       = 7;
    localparam int LCD_DATA_W       = 8;
    localparam int LCD_TIMEOUT_DFLT = 65535;

    typedef enum logic [1:0] {
        s_DRAIN,
        s_IDLE,
        s_ISSUE,
        s_WAIT
    } lcd_state_t;

    // width of an index into n requesters, never narrower than one bit
    function automatic int lcd_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lcd_rr_picker.sv
// lcd_rr_picker: combinational round-robin pick of the first request at or after a pointer
module lcd_rr_picker
    import lcd_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = lcd_idx_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_index,
    output logic          o_valid
);

    // scan N slots starting at the pointer, wrapping, and keep the first hit
    always_comb begin
        o_grant = '0;
        o_index = '0;
        o_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!o_valid && i_req[(int'(i_ptr) + i) % N]) begin
                o_valid = 1'b1;
                o_index = IW'((int'(i_ptr) + i) % N);
                o_grant[(int'(i_ptr) + i) % N] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_tcvr_arbiter.sv
// lcd_tcvr_arbiter: round-robin sharing of one lcd_tcvr among NUM_REQ requesters.
// Optional transaction abort timer enabled by defining LCD_ARB_TIMEOUT_EN.
module lcd_tcvr_arbiter
    import lcd_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = LCD_TIMEOUT_DFLT
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ-1:0]            i_write,
    input  logic [LCD_ADDR_W*NUM_REQ-1:0] i_addr,
    input  logic [LCD_DATA_W*NUM_REQ-1:0] i_data,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic [NUM_REQ-1:0]            o_ack,
    output logic [LCD_DATA_W-1:0]         o_rdata,
    output logic                          o_txBegin,
    output logic                          o_rxBegin,
    output logic [LCD_ADDR_W-1:0]         o_address,
    output logic [LCD_DATA_W-1:0]         o_txData,
    input  logic                          i_txBusy,
    input  logic                          i_rxBusy,
    input  logic                          i_txDone,
    input  logic                          i_rxDone,
    input  logic [LCD_DATA_W-1:0]         i_rxData,
    output logic                          o_timeout
);

    localparam int IW = lcd_idx_w(NUM_REQ);

    lcd_state_t              r_state, w_next;
    logic [IW-1:0]           r_ptr, r_idx, w_pick_idx;
    logic [NUM_REQ-1:0]      r_grant, r_ack, w_pick_grant;
    logic                    w_pick_valid, r_wr, r_done_prev;
    logic                    w_done, w_busy, w_edge, w_expire, w_finish, w_tcvr_quiet;
    logic [LCD_ADDR_W-1:0]   r_address;
    logic [LCD_DATA_W-1:0]   r_txdata, r_rdata;

    lcd_rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_grant),
        .o_index (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_done       = r_wr ? i_txDone : i_rxDone;
    assign w_busy       = r_wr ? i_txBusy : i_rxBusy;
    assign w_edge       = (r_state == s_WAIT) && w_done && !r_done_prev;
    assign w_finish     = w_edge || w_expire;
    assign w_tcvr_quiet = !(i_txBusy || i_rxBusy || i_txDone || i_rxDone);

    assign o_grant   = r_grant;
    assign o_ack     = r_ack;
    assign o_rdata   = r_rdata;
    assign o_address = r_address;
    assign o_txData  = r_txdata;
    assign o_txBegin = (r_state == s_ISSUE) && r_wr;
    assign o_rxBegin = (r_state == s_ISSUE) && !r_wr;

`ifdef LCD_ARB_TIMEOUT_EN
    logic [15:0] r_cnt;
    logic        r_timeout;

    assign w_expire  = (r_state == s_ISSUE || r_state == s_WAIT) && r_cnt == 16'(TIMEOUT_CYCLES - 1);
    assign o_timeout = r_timeout;

    // abort timer: cleared while idle so it restarts on entry to issue, counts through issue and wait
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire && !w_edge;
            r_cnt     <= (r_state == s_ISSUE || r_state == s_WAIT) ? r_cnt + 16'd1 : '0;
        end
    end
`else
    assign w_expire  = 1'b0;
    assign o_timeout = 1'b0;
`endif

    if (NUM_REQ < 1 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("lcd_tcvr_arbiter: parameter out of range");
    end

    // state register; reset drains since the transceiver itself is never reset
    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= s_DRAIN;
        else         r_state <= w_next;
    end

    // next-state: drain until quiet, arbitrate, hold begin until busy, wait for done rise
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            s_DRAIN: w_next = w_tcvr_quiet ? s_IDLE : s_DRAIN;
            s_IDLE:  w_next = w_pick_valid ? s_ISSUE : s_IDLE;
            s_ISSUE: w_next = w_expire ? s_DRAIN : (w_busy ? s_WAIT : s_ISSUE);
            s_WAIT:  w_next = w_finish ? s_DRAIN : s_WAIT;
            default: w_next = s_DRAIN;
        endcase
    end

    // latch the winner's command, then ack/release and advance the pointer on completion
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_ptr       <= '0;
            r_idx       <= '0;
            r_grant     <= '0;
            r_ack       <= '0;
            r_wr        <= 1'b0;
            r_done_prev <= 1'b0;
            r_address   <= '0;
            r_txdata    <= '0;
            r_rdata     <= '0;
        end else begin
            r_done_prev <= w_done;
            r_ack       <= '0;
            if (r_state == s_IDLE && w_pick_valid) begin
                r_grant   <= w_pick_grant;
                r_idx     <= w_pick_idx;
                r_wr      <= i_write[w_pick_idx];
                r_address <= i_addr[int'(w_pick_idx)*LCD_ADDR_W +: LCD_ADDR_W];
                r_txdata  <= i_data[int'(w_pick_idx)*LCD_DATA_W +: LCD_DATA_W];
            end
            if (w_finish) begin
                r_ack   <= r_grant;
                r_grant <= '0;
                r_ptr   <= (r_idx == IW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
                if (w_edge && !r_wr) r_rdata <= i_rxData;
            end
        end
    end

endmodule
